// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg
//   Shared register-file widths and writeback-queue defaults used by the
//   writeback queue, its enqueue interface and the bypass match logic.
//   RegBus      regfile data width
//   RegAddrBus  regfile address width
//   RegNum      number of architectural registers
//   ZeroWord    all-zero data word
//   WriteEnable / WriteDisable  regfile write-enable levels
//   WBQ_DEPTH   default queue depth
package wb_queue_pkg;

    localparam int         RegBus       = 32;
    localparam int         RegAddrBus   = 5;
    localparam int         RegNum       = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;
    localparam int         WBQ_DEPTH    = 4;

endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if
//   Enqueue handshake between the MEM/WB side (master) and the writeback
//   queue (slave).
//   in_valid  master->slave  write request valid
//   in_ready  slave->master  queue can accept this cycle
//   in_waddr  master->slave  destination register
//   in_wdata  master->slave  write data
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DW = RegBus,
    parameter int AW = RegAddrBus
) ();

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_waddr;
    logic [DW-1:0] in_wdata;

    modport master (
        output in_valid,
        output in_waddr,
        output in_wdata,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_waddr,
        input  in_wdata,
        output in_ready
    );

endinterface

// File: rtl/wb_queue_match.sv
// wbq_match
//   Combinational bypass lookup for one ID-stage read port. Searches the
//   live queue entries and the registered regfile write for the youngest
//   pending value of qaddr.
//   qaddr     query address (address 0 never hits)
//   ent_addr  queue entry addresses, indexed by storage slot
//   ent_data  queue entry data, indexed by storage slot
//   head      slot of the oldest live entry
//   count     number of live entries starting at head
//   out_we    output register holds a write being retired
//   out_addr  output register address
//   out_data  output register data
//   hit       qaddr has a pending write
//   data      youngest pending data for qaddr, 0 when no hit
module wbq_match
    import wb_queue_pkg::*;
#(
    parameter int  DW    = RegBus,
    parameter int  AW    = RegAddrBus,
    parameter int  DEPTH = WBQ_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]             qaddr,
    input  logic [DEPTH-1:0][AW-1:0]  ent_addr,
    input  logic [DEPTH-1:0][DW-1:0]  ent_data,
    input  logic [PW-1:0]             head,
    input  logic [PW:0]               count,
    input  logic                      out_we,
    input  logic [AW-1:0]             out_addr,
    input  logic [DW-1:0]             out_data,
    output logic                      hit,
    output logic [DW-1:0]             data
);

    logic [PW-1:0] idx;

    // Candidates are visited oldest to youngest, so a later match simply
    // overwrites an earlier one and the youngest write wins. The output
    // register is older than every queue entry and is visited first.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (out_we && (out_addr == qaddr)) begin
            hit  = 1'b1;
            data = out_data;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && (ent_addr[idx] == qaddr)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
        if (qaddr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/wb_queue.sv
// wb_queue
//   In-order writeback queue in front of the single regfile write port.
//   Buffers register-write requests, retires at most one per cycle and
//   answers two bypass queries with the youngest pending value.
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-low
//   enq        enqueue handshake (slave side of wb_queue_if)
//   hold       pause retirement; enqueue still allowed
//   we/waddr/wdata  registered regfile write port
//   rq1_addr/rq1_hit/rq1_data  bypass query, read port 1
//   rq2_addr/rq2_hit/rq2_data  bypass query, read port 2
//   empty      nothing queued and no write on the regfile port
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int  DW    = RegBus,
    parameter int  AW    = RegAddrBus,
    parameter int  DEPTH = WBQ_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    wb_queue_if.slave     enq,
    input  logic          hold,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] rq1_addr,
    output logic          rq1_hit,
    output logic [DW-1:0] rq1_data,
    input  logic [AW-1:0] rq2_addr,
    output logic          rq2_hit,
    output logic [DW-1:0] rq2_data,
    output logic          empty
);

    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     accept;
    logic                     store;
    logic                     pop;

    assign full         = (count == CW'(DEPTH));
    assign enq.in_ready = rst & ~full;
    assign accept       = enq.in_valid & enq.in_ready;
    // x0 writes finish the handshake but never occupy a slot.
    assign store        = accept & (enq.in_waddr != '0);
    assign pop          = ~hold & (count != '0);
    assign empty        = (count == '0) & ~we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            we     <= WriteDisable;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            if (store) begin
                ent_addr[wr_ptr] <= enq.in_waddr;
                ent_data[wr_ptr] <= enq.in_wdata;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                we     <= WriteEnable;
                waddr  <= ent_addr[rd_ptr];
                wdata  <= ent_data[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end else begin
                we     <= WriteDisable;
            end
            count <= count + CW'(store) - CW'(pop);
        end
    end

    wbq_match #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_match1 (
        .qaddr    (rq1_addr),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (rd_ptr),
        .count    (count),
        .out_we   (we),
        .out_addr (waddr),
        .out_data (wdata),
        .hit      (rq1_hit),
        .data     (rq1_data)
    );

    wbq_match #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_match2 (
        .qaddr    (rq2_addr),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (rd_ptr),
        .count    (count),
        .out_we   (we),
        .out_addr (waddr),
        .out_data (wdata),
        .hit      (rq2_hit),
        .data     (rq2_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue
//   Directed self-checking bench for wb_queue: reset, single write latency,
//   full-queue backpressure, same-address bypass ordering, x0 filtering and
//   reset during drain.
module tb_wb_queue;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rq1_addr;
    logic        rq1_hit;
    logic [31:0] rq1_data;
    logic [4:0]  rq2_addr;
    logic        rq2_hit;
    logic [31:0] rq2_data;
    logic        empty;

    int errors = 0;
    int checks = 0;

    wb_queue_if bus ();

    wb_queue dut (
        .clk      (clk),
        .rst      (rst),
        .enq      (bus.slave),
        .hold     (hold),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rq1_addr (rq1_addr),
        .rq1_hit  (rq1_hit),
        .rq1_data (rq1_data),
        .rq2_addr (rq2_addr),
        .rq2_hit  (rq2_hit),
        .rq2_data (rq2_data),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_waddr = 5'd3;
        bus.in_wdata = 32'h0000_0033;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL reset_we got=%b exp=0", we);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty got=%b exp=1", empty);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_single;
        bus.in_valid = 1'b1;
        bus.in_waddr = 5'd5;
        bus.in_wdata = 32'hDEAD_BEEF;
        rq1_addr = 5'd5;
        #1;
        checks++;
        if (rq1_hit !== 1'b0) begin
            errors++; $display("FAIL single_inflight_hit got=%b exp=0", rq1_hit);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL single_we_early got=%b exp=0", we);
        end
        checks++;
        if (rq1_hit !== 1'b1 || rq1_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_bypass_queued got=%b/%h exp=1/deadbeef", rq1_hit, rq1_data);
        end
        step();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_retire got=%b/%0d/%h exp=1/5/deadbeef", we, waddr, wdata);
        end
        checks++;
        if (rq1_hit !== 1'b1 || rq1_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_bypass_outreg got=%b/%h exp=1/deadbeef", rq1_hit, rq1_data);
        end
        step();
        checks++;
        if (we !== 1'b0 || rq1_hit !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL single_after got we=%b hit=%b empty=%b exp=0/0/1", we, rq1_hit, empty);
        end
    endtask

    task automatic test_full;
        logic [4:0]  cap_a[$];
        logic [31:0] cap_d[$];
        int          first;
        int          last;
        logic        rdy;
        first = -1;
        last  = -1;
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_waddr = 5'(i);
            bus.in_wdata = 32'(100 + i);
            #1;
            checks++;
            if (bus.in_ready !== ((i <= 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL full_ready_%0d got=%b exp=%b", i, bus.in_ready, (i <= 4));
            end
            if (i <= 4) step();
        end
        hold = 1'b0;
        for (int c = 0; c < 10; c++) begin
            rdy = bus.in_ready;
            step();
            if (rdy) bus.in_valid = 1'b0;
            if (we === 1'b1) begin
                cap_a.push_back(waddr);
                cap_d.push_back(wdata);
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (cap_a.size() != 5) begin
            errors++; $display("FAIL full_pulse_count got=%0d exp=5", cap_a.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (cap_a[j] !== 5'(j + 1) || cap_d[j] !== 32'(101 + j)) begin
                    errors++; $display("FAIL full_order_%0d got=%0d/%0d exp=%0d/%0d", j, cap_a[j], cap_d[j], j + 1, 101 + j);
                end
            end
        end
        checks++;
        if (last - first != 4) begin
            errors++; $display("FAIL full_consecutive got_span=%0d exp=4", last - first);
        end
    endtask

    task automatic test_order;
        hold = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_waddr = 5'd7;
        bus.in_wdata = 32'd1;
        step();
        bus.in_wdata = 32'd2;
        step();
        bus.in_valid = 1'b0;
        rq2_addr = 5'd7;
        #1;
        checks++;
        if (rq2_hit !== 1'b1 || rq2_data !== 32'd2) begin
            errors++; $display("FAIL order_bypass got=%b/%0d exp=1/2", rq2_hit, rq2_data);
        end
        hold = 1'b0;
        step();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'd1) begin
            errors++; $display("FAIL order_first got=%b/%0d/%0d exp=1/7/1", we, waddr, wdata);
        end
        checks++;
        if (rq2_hit !== 1'b1 || rq2_data !== 32'd2) begin
            errors++; $display("FAIL order_bypass_young got=%b/%0d exp=1/2", rq2_hit, rq2_data);
        end
        step();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'd2) begin
            errors++; $display("FAIL order_second got=%b/%0d/%0d exp=1/7/2", we, waddr, wdata);
        end
        step();
        checks++;
        if (we !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL order_drained got we=%b empty=%b exp=0/1", we, empty);
        end
    endtask

    task automatic test_x0;
        int pulses;
        pulses = 0;
        bus.in_valid = 1'b1;
        bus.in_waddr = 5'd0;
        bus.in_wdata = 32'h0000_1234;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready got=%b exp=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        rq1_addr = 5'd0;
        #1;
        checks++;
        if (rq1_hit !== 1'b0 || rq1_data !== 32'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL x0_lookup got hit=%b data=%h empty=%b exp=0/0/1", rq1_hit, rq1_data, empty);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (we === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL x0_we got_pulses=%0d exp=0", pulses);
        end
    endtask

    task automatic test_reset_drain;
        int pulses;
        pulses = 0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_waddr = 5'(10 + i);
            bus.in_wdata = 32'(500 + i);
            step();
        end
        bus.in_valid = 1'b0;
        hold = 1'b0;
        step();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'd500) begin
            errors++; $display("FAIL drain_first got=%b/%0d/%0d exp=1/10/500", we, waddr, wdata);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        if (we === 1'b1) pulses++;
        for (int c = 0; c < 4; c++) begin
            step();
            if (we === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL drain_no_pulses got=%0d exp=0", pulses);
        end
        rq1_addr = 5'd11;
        rq2_addr = 5'd12;
        #1;
        checks++;
        if (empty !== 1'b1 || rq1_hit !== 1'b0 || rq2_hit !== 1'b0) begin
            errors++; $display("FAIL drain_state got empty=%b hit1=%b hit2=%b exp=1/0/0", empty, rq1_hit, rq2_hit);
        end
    endtask

    initial begin
        rst          = 1'b0;
        hold         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_waddr = '0;
        bus.in_wdata = '0;
        rq1_addr     = '0;
        rq2_addr     = '0;
        test_reset();
        test_single();
        test_full();
        test_order();
        test_x0();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
